gbt_frame_decoder: RTL and testbench



---
 rtl/gbt_frame_decoder_pkg.sv | 31 +++
 rtl/gbt_frame_decoder_sat_counter.sv | 35 +++
 rtl/gbt_frame_decoder.sv | 156 +++++++++++++++
 tb/tb_gbt_frame_decoder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gbt_frame_decoder_pkg.sv
// Shared types and helpers for the GBT user-frame decoder: frame layout,
// frame type codes, lock state encoding and the payload checksum.
package gbt_frame_pkg;

    typedef struct packed {
        logic [7:0]  seq;
        logic [3:0]  ftype;
        logic [3:0]  chk;
        logic [63:0] payload;
    } t_gbt_frame;

    localparam logic [3:0] FRAME_TYPE_DATA = 4'hA;
    localparam logic [3:0] FRAME_TYPE_IDLE = 4'h5;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_CHECKING = 2'd1,
        ST_LOCKED   = 2'd2
    } t_lock_state;

    // XOR of the sixteen payload nibbles.
    function automatic logic [3:0] frame_checksum(input logic [63:0] payload);
        logic [3:0] acc;
        acc = 4'h0;
        for (int i = 0; i < 16; i++) begin
            acc = acc ^ payload[i*4 +: 4];
        end
        return acc;
    endfunction

endpackage

// File: rtl/gbt_frame_decoder_sat_counter.sv
// Saturating up-counter with a synchronous clear that overrides any
// coincident increment.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/gbt_frame_decoder.sv
// GBT user-frame decoder: validates checksum, type and sequence number,
// tracks link lock and forwards motor payloads while locked.
import gbt_frame_pkg::*;

module gbt_frame_decoder #(
    parameter int LOCK_FRAMES   = 4,
    parameter int UNLOCK_ERRORS = 3,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 link_ready_i,
    input  logic                 frame_valid_i,
    input  logic [79:0]          frame_i,
    input  logic                 clear_cnt_i,
    output logic [63:0]          motor_data_o,
    output logic                 motor_valid_o,
    output logic                 locked_o,
    output logic [CNT_WIDTH-1:0] chk_err_cnt_o,
    output logic [CNT_WIDTH-1:0] seq_err_cnt_o,
    output logic [CNT_WIDTH-1:0] frame_cnt_o
);

    localparam logic [8:0] LOCK_N   = 9'(LOCK_FRAMES);
    localparam logic [8:0] UNLOCK_N = 9'(UNLOCK_ERRORS);

    logic        vld_p0_q;
    logic        link_p0_q;
    logic        clr_p0_q;
    t_gbt_frame  frame_p0_q;

    t_lock_state state_q;
    logic [7:0]  good_cnt_q;
    logic [7:0]  bad_cnt_q;
    logic [7:0]  exp_seq_q;
    logic [63:0] motor_data_q;
    logic        motor_valid_q;

    logic chk_ok;
    logic is_data;
    logic good;
    logic act;
    logic seq_mis;

    // Stage p0: input capture, keeps link_ready aligned with its frame
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p0_q   <= 1'b0;
            link_p0_q  <= 1'b0;
            clr_p0_q   <= 1'b0;
            frame_p0_q <= '0;
        end else begin
            vld_p0_q   <= frame_valid_i;
            link_p0_q  <= link_ready_i;
            clr_p0_q   <= clear_cnt_i;
            frame_p0_q <= frame_i;
        end
    end

    always_comb begin
        chk_ok  = (frame_checksum(frame_p0_q.payload) == frame_p0_q.chk);
        is_data = (frame_p0_q.ftype == FRAME_TYPE_DATA);
        good    = chk_ok && (is_data || (frame_p0_q.ftype == FRAME_TYPE_IDLE));
        act     = vld_p0_q && link_p0_q;
        seq_mis = act && (state_q != ST_UNLOCKED) && (frame_p0_q.seq != exp_seq_q);
    end

    // Stage p1: lock FSM, sequence tracking and payload delivery
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_UNLOCKED;
            good_cnt_q    <= 8'd0;
            bad_cnt_q     <= 8'd0;
            exp_seq_q     <= 8'd0;
            motor_data_q  <= 64'd0;
            motor_valid_q <= 1'b0;
        end else begin
            motor_valid_q <= 1'b0;
            if (!link_p0_q) begin
                state_q    <= ST_UNLOCKED;
                good_cnt_q <= 8'd0;
                bad_cnt_q  <= 8'd0;
            end else if (vld_p0_q) begin
                exp_seq_q <= frame_p0_q.seq + 8'd1;
                case (state_q)
                    ST_UNLOCKED: begin
                        if (good) begin
                            good_cnt_q <= 8'd1;
                            state_q    <= (LOCK_N == 9'd1) ? ST_LOCKED : ST_CHECKING;
                        end
                    end
                    ST_CHECKING: begin
                        if (!good) begin
                            state_q    <= ST_UNLOCKED;
                            good_cnt_q <= 8'd0;
                        end else if (({1'b0, good_cnt_q} + 9'd1) >= LOCK_N) begin
                            state_q    <= ST_LOCKED;
                            good_cnt_q <= 8'd0;
                            bad_cnt_q  <= 8'd0;
                        end else begin
                            good_cnt_q <= good_cnt_q + 8'd1;
                        end
                    end
                    ST_LOCKED: begin
                        if (good) begin
                            bad_cnt_q <= 8'd0;
                            if (is_data) begin
                                motor_data_q  <= frame_p0_q.payload;
                                motor_valid_q <= 1'b1;
                            end
                        end else if (({1'b0, bad_cnt_q} + 9'd1) >= UNLOCK_N) begin
                            state_q   <= ST_UNLOCKED;
                            bad_cnt_q <= 8'd0;
                        end else begin
                            bad_cnt_q <= bad_cnt_q + 8'd1;
                        end
                    end
                    default: begin
                        state_q    <= ST_UNLOCKED;
                        good_cnt_q <= 8'd0;
                        bad_cnt_q  <= 8'd0;
                    end
                endcase
            end
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_chk_cnt (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .inc_i  (act && !good),
        .clr_i  (clr_p0_q),
        .cnt_o  (chk_err_cnt_o)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_seq_cnt (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .inc_i  (seq_mis),
        .clr_i  (clr_p0_q),
        .cnt_o  (seq_err_cnt_o)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_frame_cnt (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .inc_i  (vld_p0_q),
        .clr_i  (clr_p0_q),
        .cnt_o  (frame_cnt_o)
    );

    assign motor_data_o  = motor_data_q;
    assign motor_valid_o = motor_valid_q;
    assign locked_o      = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_gbt_frame_decoder.sv
// Bench for gbt_frame_decoder: directed scenarios followed by random frames,
// checked against a frame-level behavioural model.
module tb_gbt_frame_decoder;

    localparam int LF = 4;
    localparam int UE = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        link_ready_i = 1'b0;
    logic        frame_valid_i = 1'b0;
    logic [79:0] frame_i = '0;
    logic        clear_cnt_i = 1'b0;

    logic [63:0] motor_data_o;
    logic        motor_valid_o;
    logic        locked_o;
    logic [15:0] chk_err_cnt_o, seq_err_cnt_o, frame_cnt_o;

    logic [63:0] motor_data4;
    logic        motor_valid4;
    logic        locked4;
    logic [3:0]  chk4, seq4, frm4;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    gbt_frame_decoder #(.LOCK_FRAMES(LF), .UNLOCK_ERRORS(UE), .CNT_WIDTH(16)) u_dut (
        .clk(clk), .reset_n(reset_n), .link_ready_i(link_ready_i),
        .frame_valid_i(frame_valid_i), .frame_i(frame_i), .clear_cnt_i(clear_cnt_i),
        .motor_data_o(motor_data_o), .motor_valid_o(motor_valid_o), .locked_o(locked_o),
        .chk_err_cnt_o(chk_err_cnt_o), .seq_err_cnt_o(seq_err_cnt_o), .frame_cnt_o(frame_cnt_o)
    );

    gbt_frame_decoder #(.LOCK_FRAMES(LF), .UNLOCK_ERRORS(UE), .CNT_WIDTH(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .link_ready_i(link_ready_i),
        .frame_valid_i(frame_valid_i), .frame_i(frame_i), .clear_cnt_i(clear_cnt_i),
        .motor_data_o(motor_data4), .motor_valid_o(motor_valid4), .locked_o(locked4),
        .chk_err_cnt_o(chk4), .seq_err_cnt_o(seq4), .frame_cnt_o(frm4)
    );

    // Behavioural model: 0 = unlocked, 1 = gathering good frames, 2 = locked
    int          m_mode;
    int          m_good_run, m_bad_run;
    logic [7:0]  m_next_seq;
    int          n_chk, n_seq, n_frm, n_chk4, n_seq4, n_frm4;
    logic [63:0] e_data;
    logic        e_valid, e_locked;

    function automatic logic [3:0] ref_chk(input logic [63:0] p);
        logic [3:0]  r;
        logic [63:0] mask;
        for (int b = 0; b < 4; b++) begin
            mask = 64'h1111_1111_1111_1111 << b;
            r[b] = ^(p & mask);
        end
        return r;
    endfunction

    function automatic logic [79:0] mk(input logic [7:0] seq, input logic [3:0] typ,
                                       input logic [63:0] p, input bit corrupt);
        logic [3:0] c;
        c = ref_chk(p) ^ (corrupt ? 4'h3 : 4'h0);
        return {seq, typ, c, p};
    endfunction

    function automatic int sat(input int c, input bit inc, input bit clr, input int mx);
        if (clr) return 0;
        if (inc && c < mx) return c + 1;
        return c;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_good_run = 0; m_bad_run = 0; m_next_seq = 8'd0;
        n_chk = 0; n_seq = 0; n_frm = 0; n_chk4 = 0; n_seq4 = 0; n_frm4 = 0;
        e_data = 64'd0; e_valid = 1'b0; e_locked = 1'b0;
    endtask

    task automatic model_step(input bit v, input logic [79:0] f, input bit lr, input bit clr);
        bit good, ic, is;
        logic [3:0] typ;
        typ = f[71:68];
        good = (ref_chk(f[63:0]) == f[67:64]) && (typ == 4'hA || typ == 4'h5);
        ic = 0; is = 0;
        e_valid = 1'b0;
        if (!lr) begin
            m_mode = 0; m_good_run = 0; m_bad_run = 0;
        end else if (v) begin
            ic = !good;
            is = (m_mode != 0) && (f[79:72] != m_next_seq);
            m_next_seq = f[79:72] + 8'd1;
            if (m_mode == 0) begin
                if (good) begin m_good_run = 1; m_mode = (LF == 1) ? 2 : 1; end
            end else if (m_mode == 1) begin
                if (good) begin
                    m_good_run++;
                    if (m_good_run >= LF) m_mode = 2;
                end else begin
                    m_mode = 0; m_good_run = 0;
                end
            end else begin
                if (good) begin
                    m_bad_run = 0;
                    if (typ == 4'hA) begin e_valid = 1'b1; e_data = f[63:0]; end
                end else begin
                    m_bad_run++;
                    if (m_bad_run >= UE) begin m_mode = 0; m_bad_run = 0; end
                end
            end
        end
        n_chk  = sat(n_chk,  ic, clr, 65535);
        n_seq  = sat(n_seq,  is, clr, 65535);
        n_frm  = sat(n_frm,  v,  clr, 65535);
        n_chk4 = sat(n_chk4, ic, clr, 15);
        n_seq4 = sat(n_seq4, is, clr, 15);
        n_frm4 = sat(n_frm4, v,  clr, 15);
        e_locked = (m_mode == 2);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        chk("motor_data",  motor_data_o, e_data);
        chk("motor_valid", 64'(motor_valid_o), 64'(e_valid));
        chk("locked",      64'(locked_o), 64'(e_locked));
        chk("chk_cnt",     64'(chk_err_cnt_o), 64'(n_chk));
        chk("seq_cnt",     64'(seq_err_cnt_o), 64'(n_seq));
        chk("frame_cnt",   64'(frame_cnt_o), 64'(n_frm));
        chk("locked_w4",   64'(locked4), 64'(e_locked));
        chk("chk_cnt_w4",  64'(chk4), 64'(n_chk4));
        chk("seq_cnt_w4",  64'(seq4), 64'(n_seq4));
        chk("frame_cnt_w4", 64'(frm4), 64'(n_frm4));
    endtask

    // Drive one cycle; outputs seen after this edge reflect the previous cycle's inputs.
    task automatic tick(input bit v, input logic [79:0] f, input bit lr, input bit clr);
        frame_valid_i = v; frame_i = f; link_ready_i = lr; clear_cnt_i = clr;
        @(posedge clk); #1;
        compare_all();
        model_step(v, f, lr, clr);
    endtask

    task automatic idle();
        tick(1'b0, 80'd0, 1'b1, 1'b0);
    endtask

    task automatic send(input logic [7:0] seq, input logic [3:0] typ, input bit corrupt);
        tick(1'b1, mk(seq, typ, {$urandom, $urandom}, corrupt), 1'b1, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  s;
        logic [3:0]  t;
        logic [63:0] p;
        bit v, lr, clr, cor;

        model_reset();
        #2;
        chk("rst_valid", 64'(motor_valid_o), 64'd0);
        chk("rst_locked", 64'(locked_o), 64'd0);
        chk("rst_data", motor_data_o, 64'd0);
        #20 reset_n = 1'b1;
        link_ready_i = 1'b1;
        idle();

        // Lock with seq 0..3, first delivery is seq 4
        for (int i = 0; i < 4; i++) send(8'(i), 4'hA, 1'b0);
        tick(1'b1, mk(8'd4, 4'hA, 64'h0123_4567_89AB_CDEF, 1'b0), 1'b1, 1'b0);
        chk("lock_after4", 64'(locked_o), 64'd1);
        chk("no_early_delivery", 64'(motor_valid_o), 64'd0);
        idle();
        chk("first_delivery_valid", 64'(motor_valid_o), 64'd1);
        chk("first_delivery_data", motor_data_o, 64'h0123_4567_89AB_CDEF);

        // Bad, bad, good, bad, bad, bad
        send(8'd5, 4'hA, 1'b1);
        send(8'd6, 4'hA, 1'b1);
        send(8'd7, 4'hA, 1'b0);
        send(8'd8, 4'hA, 1'b1);
        send(8'd9, 4'hA, 1'b1);
        send(8'd10, 4'hA, 1'b1);
        chk("hold_lock_2bad", 64'(locked_o), 64'd1);
        idle();
        chk("unlock_3bad", 64'(locked_o), 64'd0);
        chk("chk_err_5", 64'(chk_err_cnt_o), 64'd5);

        // Relock across the seq wrap, then a seq jump while locked
        for (int i = 250; i < 254; i++) send(8'(i), 4'h5, 1'b0);
        s = 8'd254;
        for (int i = 0; i < 13; i++) begin send(s, 4'hA, 1'b0); s = s + 8'd1; end
        idle();
        chk("seq_wrap_no_err", 64'(seq_err_cnt_o), 64'd0);
        tick(1'b1, mk(8'd12, 4'hA, 64'hDEAD_BEEF_0000_1234, 1'b0), 1'b1, 1'b0);
        idle();
        chk("seq_jump_err", 64'(seq_err_cnt_o), 64'd1);
        chk("seq_jump_delivered", motor_data_o, 64'hDEAD_BEEF_0000_1234);
        chk("seq_jump_locked", 64'(locked_o), 64'd1);

        // Link drop with a coincident good frame
        tick(1'b1, mk(8'd13, 4'hA, 64'h5555_AAAA_5555_AAAA, 1'b0), 1'b0, 1'b0);
        idle();
        chk("drop_no_delivery", 64'(motor_valid_o), 64'd0);
        chk("drop_unlocked", 64'(locked_o), 64'd0);
        for (int i = 14; i < 18; i++) send(8'(i), 4'hA, 1'b0);
        chk("relock_not_yet", 64'(locked_o), 64'd0);
        idle();
        chk("relock_4", 64'(locked_o), 64'd1);

        // Saturation of the narrow counters and clear priority
        for (int i = 18; i < 38; i++) send(8'(i), 4'hA, 1'b1);
        idle();
        chk("sat_chk_w4", 64'(chk4), 64'd15);
        tick(1'b1, mk(8'd38, 4'h3, 64'h1, 1'b0), 1'b1, 1'b1);
        idle();
        chk("clr_priority_w4", 64'(chk4), 64'd0);
        chk("clr_priority_w16", 64'(chk_err_cnt_o), 64'd0);

        // Asynchronous reset while locked
        for (int i = 40; i < 45; i++) send(8'(i), 4'hA, 1'b0);
        idle();
        chk("locked_before_reset", 64'(locked_o), 64'd1);
        frame_valid_i = 1'b0; frame_i = '0;
        #3 reset_n = 1'b0;
        #1;
        chk("async_rst_locked", 64'(locked_o), 64'd0);
        chk("async_rst_data", motor_data_o, 64'd0);
        chk("async_rst_valid", 64'(motor_valid_o), 64'd0);
        chk("async_rst_frames", 64'(frame_cnt_o), 64'd0);
        model_reset();
        #12 reset_n = 1'b1;

        // Random traffic
        s = 8'd0;
        for (int i = 0; i < 400; i++) begin
            v   = ($urandom_range(0, 3) != 0);
            lr  = ($urandom_range(0, 29) != 0);
            clr = ($urandom_range(0, 49) == 0);
            cor = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 9))
                0:       t = 4'h5;
                1:       t = 4'($urandom);
                default: t = 4'hA;
            endcase
            if ($urandom_range(0, 14) == 0) s = 8'($urandom);
            p = {$urandom, $urandom};
            tick(v, mk(s, t, p, cor), lr, clr);
            if (v) s = s + 8'd1;
        end
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
